// File: rtl/inst_mem_if.sv
// Fetch-side instruction memory bus: the fetch unit (master) drives PC and
// instrmem_rd, the memory (slave) answers with instr_dout and complete_instr.
interface inst_mem_if;
  logic [15:0] PC;
  logic        instrmem_rd;
  logic [15:0] instr_dout;
  logic        complete_instr;

  // Handshake: instrmem_rd is a level request, sampled only while the memory is
  // idle; complete_instr is a one-cycle strobe during which instr_dout is valid,
  // and instr_dout holds its value until the next response.
  modport master (output PC, instrmem_rd, input  instr_dout, complete_instr);
  modport slave  (input  PC, instrmem_rd, output instr_dout, complete_instr);
endinterface

// File: rtl/inst_mem_responder.sv
// Instruction memory responder with programmable wait states and a preload port.
// Optional macro INST_MEM_RANGE_CHECK_EN adds addr_err for PC beyond the array.
module inst_mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  inst_mem_if.slave         bus,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [15:0]       load_data,
`ifdef INST_MEM_RANGE_CHECK_EN
  output logic              addr_err,
`endif
  output logic [1:0]        o_dbg_state
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  w_addr_next;
  logic [15:0]        r_dout;
  logic [15:0]        w_dout_next;
  logic               r_cmp;
  logic               w_cmp_next;
  logic [15:0]        r_mem [2**ADDR_W];

`ifdef INST_MEM_RANGE_CHECK_EN
  logic r_oor;
  logic w_oor_next;
  logic r_err;
  logic w_err_next;
`else
  logic w_unused_pc_hi;
  assign w_unused_pc_hi = ^bus.PC[15:ADDR_W];
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.instrmem_rd) w_state_next = S_WAIT;
      S_WAIT:  if (r_cnt == '0)     w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Array read uses the pre-edge contents, so a same-edge preload is seen only later.
  always_comb begin
    w_cnt_next  = r_cnt;
    w_addr_next = r_addr;
    w_dout_next = r_dout;
    w_cmp_next  = 1'b0;
`ifdef INST_MEM_RANGE_CHECK_EN
    w_oor_next  = r_oor;
    w_err_next  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.instrmem_rd) begin
          w_addr_next = bus.PC[ADDR_W-1:0];
          w_cnt_next  = CNT_W'(LATENCY);
`ifdef INST_MEM_RANGE_CHECK_EN
          w_oor_next  = |bus.PC[15:ADDR_W];
`endif
        end
      end
      S_WAIT: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - 1'b1;
        end else begin
          w_cmp_next = 1'b1;
`ifdef INST_MEM_RANGE_CHECK_EN
          if (r_oor) begin
            w_dout_next = 16'h0000;
            w_err_next  = 1'b1;
          end else begin
            w_dout_next = r_mem[r_addr];
          end
`else
          w_dout_next = r_mem[r_addr];
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_addr <= '0;
      r_dout <= 16'h0000;
      r_cmp  <= 1'b0;
`ifdef INST_MEM_RANGE_CHECK_EN
      r_oor  <= 1'b0;
      r_err  <= 1'b0;
`endif
    end else begin
      r_cnt  <= w_cnt_next;
      r_addr <= w_addr_next;
      r_dout <= w_dout_next;
      r_cmp  <= w_cmp_next;
`ifdef INST_MEM_RANGE_CHECK_EN
      r_oor  <= w_oor_next;
      r_err  <= w_err_next;
`endif
    end
  end

  // Contents survive reset so a preloaded program outlives a core reset.
  always_ff @(posedge clock) begin
    if (load_en) r_mem[load_addr] <= load_data;
  end

  assign bus.instr_dout     = r_dout;
  assign bus.complete_instr = r_cmp;
  assign o_dbg_state        = r_state;
`ifdef INST_MEM_RANGE_CHECK_EN
  assign addr_err           = r_err;
`endif

endmodule

// File: tb/tb_inst_mem_responder.sv
// Bench for inst_mem_responder: LATENCY=2 and LATENCY=0 instances share the preload port.
module tb_inst_mem_responder;
  localparam int ADDR_W = 8;
  localparam int LAT    = 2;
`ifdef INST_MEM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc++;

  inst_mem_if bus ();
  inst_mem_if bus0 ();
  logic              load_en   = 1'b0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [15:0]       load_data = '0;
  logic [1:0]        st, st0;
`ifdef INST_MEM_RANGE_CHECK_EN
  logic addr_err, addr_err0;
`endif

  inst_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .bus(bus), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data),
`ifdef INST_MEM_RANGE_CHECK_EN
    .addr_err(addr_err),
`endif
    .o_dbg_state(st));

  inst_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(0)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data),
`ifdef INST_MEM_RANGE_CHECK_EN
    .addr_err(addr_err0),
`endif
    .o_dbg_state(st0));

  // scoreboard
  logic [15:0] exp_q[$];
  logic        experr_q[$];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic cmp_of(input bit sel);
    return sel ? bus0.complete_instr : bus.complete_instr;
  endfunction
  function automatic logic [15:0] dout_of(input bit sel);
    return sel ? bus0.instr_dout : bus.instr_dout;
  endfunction
  function automatic logic err_of(input bit sel);
`ifdef INST_MEM_RANGE_CHECK_EN
    return sel ? addr_err0 : addr_err;
`else
    return sel ? 1'b0 : 1'b0;
`endif
  endfunction

  // driver tasks
  task automatic drive(input bit sel, input logic [15:0] pc, input logic rd);
    if (sel) begin bus0.PC = pc; bus0.instrmem_rd = rd; end
    else     begin bus.PC  = pc; bus.instrmem_rd  = rd; end
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clock); #1;
    load_en = 1'b0;
  endtask

  // One request; optional preload to the same address set up after edge ld_k.
  task automatic rd_req(input bit sel, input logic [15:0] pc, input logic [15:0] exp,
                        input bit eerr, input int ld_k, input logic [15:0] ld_d,
                        input string nm);
    int lat;
    int k;
    bit seen;
    logic [15:0] e;
    logic        ee;
    lat = sel ? 0 : LAT;
    exp_q.push_back(exp);
    experr_q.push_back(eerr);
    drive(sel, pc, 1'b1);
    @(posedge clock); #1;
    drive(sel, pc ^ 16'h0005, 1'b0);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      if (k == ld_k) begin
        load_en = 1'b1; load_addr = pc[7:0]; load_data = ld_d;
      end else begin
        load_en = 1'b0;
      end
      @(posedge clock); #1;
      k++;
      if (cmp_of(sel)) seen = 1'b1;
    end
    load_en = 1'b0;
    chk({nm, " latency"}, seen ? k : -1, lat + 1);
    e  = exp_q.pop_front();
    ee = experr_q.pop_front();
    chk({nm, " dout"}, dout_of(sel), e);
    chk({nm, " err"}, err_of(sel), ee);
    drive(sel, ~pc, 1'b0);
    @(posedge clock); #1;
    chk({nm, " strobe low"}, cmp_of(sel), 1'b0);
    chk({nm, " dout held"}, dout_of(sel), e);
    chk({nm, " err low"}, err_of(sel), 1'b0);
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    bit          nopre;
    logic [15:0] pc;
    bit          sel;
    int          ld_k;
    logic [15:0] ld_d;
    logic [15:0] exp_dout;
    bit          exp_err;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] a, input logic [15:0] d, input bit np,
                              input logic [15:0] pc, input bit sel, input int ldk,
                              input logic [15:0] ldd, input logic [15:0] ed, input bit ee);
    vec_t v;
    v.addr = a; v.data = d; v.nopre = np; v.pc = pc; v.sel = sel;
    v.ld_k = ldk; v.ld_d = ldd; v.exp_dout = ed; v.exp_err = ee;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int   t1;
    int   k;
    bit   seen;
    vecs[0] = mk(8'h10, 16'h1234, 0, 16'h0010, 0, -1, 16'h0, 16'h1234, 0);
    vecs[1] = mk(8'h00, 16'h0F0F, 0, 16'h0000, 0, -1, 16'h0, 16'h0F0F, 0);
    vecs[2] = mk(8'hFF, 16'hBEEF, 0, 16'h00FF, 0, -1, 16'h0, 16'hBEEF, 0);
    vecs[3] = mk(8'h10, 16'h1234, 0, 16'h0110, 0, -1, 16'h0, RC ? 16'h0000 : 16'h1234, RC);
    vecs[4] = mk(8'h33, 16'hA5A5, 0, 16'h0033, 1, -1, 16'h0, 16'hA5A5, 0);
    vecs[5] = mk(8'h80, 16'h7E81, 0, 16'hFF80, 1, -1, 16'h0, RC ? 16'h0000 : 16'h7E81, RC);
    vecs[6] = mk(8'h10, 16'h1234, 0, 16'h0010, 0, LAT, 16'hABCD, 16'h1234, 0);
    vecs[7] = mk(8'h10, 16'h0000, 1, 16'h0010, 0, -1, 16'h0, 16'hABCD, 0);
    vecs[8] = mk(8'h44, 16'h1111, 0, 16'h0044, 0, 0, 16'h2222, 16'h2222, 0);

    drive(0, 16'h0, 1'b0);
    drive(1, 16'h0, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    chk("reset strobe", bus.complete_instr, 1'b0);
    chk("reset dout", bus.instr_dout, 16'h0000);
    chk("reset state", st, 2'd0);
    chk("reset dout lat0", bus0.instr_dout, 16'h0000);
    chk("reset err", err_of(0), 1'b0);
    reset = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 9; i++) begin
      if (!vecs[i].nopre) preload(vecs[i].addr, vecs[i].data);
      rd_req(vecs[i].sel, vecs[i].pc, vecs[i].exp_dout, vecs[i].exp_err,
             vecs[i].ld_k, vecs[i].ld_d, $sformatf("vec%0d", i));
    end

    // back-to-back with request held high
    preload(8'h20, 16'h5020);
    preload(8'h21, 16'hE002);
    exp_q.push_back(16'h5020);
    exp_q.push_back(16'hE002);
    drive(0, 16'h0020, 1'b1);
    t1 = 0;
    for (int r = 0; r < 2; r++) begin
      k = 0;
      seen = 1'b0;
      while (!seen && k < 40) begin
        @(posedge clock); #1;
        k++;
        if (bus.complete_instr) seen = 1'b1;
      end
      chk($sformatf("b2b%0d seen", r), seen, 1'b1);
      chk($sformatf("b2b%0d dout", r), bus.instr_dout, exp_q.pop_front());
      if (r == 0) begin
        t1 = cyc;
        bus.PC = 16'h0021;
      end else begin
        chk("b2b gap", cyc - t1, LAT + 3);
        drive(0, 16'h0021, 1'b0);
      end
    end
    repeat (2) @(posedge clock);
    #1;

    // reset during WAIT aborts the transaction
    drive(0, 16'h0010, 1'b1);
    @(posedge clock); #1;
    drive(0, 16'h0010, 1'b0);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("abort dout in reset", bus.instr_dout, 16'h0000);
    reset = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clock); #1;
      if (bus.complete_instr) seen = 1'b1;
    end
    chk("abort no strobe", seen, 1'b0);
    chk("abort dout", bus.instr_dout, 16'h0000);
    chk("abort state", st, 2'd0);
    rd_req(0, 16'h0000, 16'h0F0F, 0, -1, 16'h0, "after abort");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
